// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode classes, func3/func7 values,
// operation enum and immediate-format selector.
package decode_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned CLASS_W = 7;

    // Opcode classes (inst[6:0])
    localparam logic [CLASS_W-1:0] CLS_LUI   = 7'b0110111;
    localparam logic [CLASS_W-1:0] CLS_AUIPC = 7'b0010111;
    localparam logic [CLASS_W-1:0] CLS_JAL   = 7'b1101111;
    localparam logic [CLASS_W-1:0] CLS_JALR  = 7'b1100111;
    localparam logic [CLASS_W-1:0] CLS_B     = 7'b1100011;
    localparam logic [CLASS_W-1:0] CLS_LD    = 7'b0000011;
    localparam logic [CLASS_W-1:0] CLS_ST    = 7'b0100011;
    localparam logic [CLASS_W-1:0] CLS_RI    = 7'b0010011;
    localparam logic [CLASS_W-1:0] CLS_RR    = 7'b0110011;
    // All-zero opcode is not an RV32I class, so it marks "no operation"
    localparam logic [CLASS_W-1:0] CLASS_NOP = 7'b0000000;

    // Register name used for unused operand/destination fields
    localparam int unsigned NAME_FREE = 0;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [OP_W-1:0] {
        OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_SUB
    } op_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_t;

    // Base ALU op for a func3 value (func7 = 0000000 variant)
    function automatic op_t alu_op(input logic [2:0] f3);
        op_t op;
        case (f3)
            F3_ADD:  op = OP_ADD;
            F3_SLL:  op = OP_SLL;
            F3_SLT:  op = OP_SLT;
            F3_SLTU: op = OP_SLTU;
            F3_XOR:  op = OP_XOR;
            F3_SRL:  op = OP_SRL;
            F3_OR:   op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Combinational RV32I decoder: instruction word -> op, class, immediate,
// register names, operand-use flags and illegal indication.
// Ports: inst (in); op_c, cls_c, imm_c, rs1_c, rs2_c, rd_c, use_rs1_c,
//        use_rs2_c, wr_rd_c, illegal_c (out, combinational).
module rv32i_decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NAME_W = 5
) (
    input  logic [DATA_W-1:0]  inst,
    output op_t                op_c,
    output logic [CLASS_W-1:0] cls_c,
    output logic [DATA_W-1:0]  imm_c,
    output logic [NAME_W-1:0]  rs1_c,
    output logic [NAME_W-1:0]  rs2_c,
    output logic [NAME_W-1:0]  rd_c,
    output logic               use_rs1_c,
    output logic               use_rs2_c,
    output logic               wr_rd_c,
    output logic               illegal_c
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    op_t  op;
    fmt_t fmt;
    logic u1, u2, wr, legal;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    assign imm_i = DATA_W'($signed(inst[31:20]));
    assign imm_s = DATA_W'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = DATA_W'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = DATA_W'({inst[31:12], 12'b0});
    assign imm_j = DATA_W'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // Opcode / func3 / func7 legality and op selection
    always_comb begin
        op    = OP_NOP;
        fmt   = FMT_R;
        u1    = 1'b0;
        u2    = 1'b0;
        wr    = 1'b0;
        legal = 1'b1;
        case (opc)
            CLS_LUI:   begin op = OP_LUI;   fmt = FMT_U; wr = 1'b1; end
            CLS_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; wr = 1'b1; end
            CLS_JAL:   begin op = OP_JAL;   fmt = FMT_J; wr = 1'b1; end
            CLS_JALR: begin
                op = OP_JALR; fmt = FMT_I; u1 = 1'b1; wr = 1'b1;
                legal = (f3 == 3'b000);
            end
            CLS_B: begin
                fmt = FMT_B; u1 = 1'b1; u2 = 1'b1;
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            CLS_LD: begin
                fmt = FMT_I; u1 = 1'b1; wr = 1'b1;
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: legal = 1'b0;
                endcase
            end
            CLS_ST: begin
                fmt = FMT_S; u1 = 1'b1; u2 = 1'b1;
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: legal = 1'b0;
                endcase
            end
            CLS_RI: begin
                fmt = FMT_I; u1 = 1'b1; wr = 1'b1;
                op  = alu_op(f3);
                // Only shift-immediates constrain func7
                if (f3 == F3_SLL && f7 != F7_ZERO) legal = 1'b0;
                if (f3 == F3_SRL) begin
                    if (f7 == F7_ALT)        op = OP_SRA;
                    else if (f7 != F7_ZERO)  legal = 1'b0;
                end
            end
            CLS_RR: begin
                fmt = FMT_R; u1 = 1'b1; u2 = 1'b1; wr = 1'b1;
                op  = alu_op(f3);
                if (f7 == F7_ALT && f3 == F3_ADD)      op = OP_SUB;
                else if (f7 == F7_ALT && f3 == F3_SRL) op = OP_SRA;
                else if (f7 != F7_ZERO)                legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Output assembly; illegal encodings collapse to an all-quiet NOP
    always_comb begin
        op_c      = OP_NOP;
        cls_c     = CLASS_NOP;
        imm_c     = '0;
        use_rs1_c = 1'b0;
        use_rs2_c = 1'b0;
        wr_rd_c   = 1'b0;
        illegal_c = ~legal;
        if (legal) begin
            op_c      = op;
            cls_c     = opc;
            use_rs1_c = u1;
            use_rs2_c = u2;
            wr_rd_c   = wr && (inst[11:7] != 5'd0);
            case (fmt)
                FMT_I:   imm_c = imm_i;
                FMT_S:   imm_c = imm_s;
                FMT_B:   imm_c = imm_b;
                FMT_U:   imm_c = imm_u;
                FMT_J:   imm_c = imm_j;
                default: imm_c = '0;
            endcase
        end
        rs1_c = use_rs1_c ? NAME_W'(inst[19:15]) : NAME_W'(NAME_FREE);
        rs2_c = use_rs2_c ? NAME_W'(inst[24:20]) : NAME_W'(NAME_FREE);
        rd_c  = wr_rd_c   ? NAME_W'(inst[11:7])  : NAME_W'(NAME_FREE);
    end

endmodule

// File: rtl/inst_decode_queue.sv
// Buffered RV32I decode stage: DEPTH-entry {pc, inst} FIFO from fetch,
// decode of the FIFO head, registered micro-op to the dispatcher, flush.
// Ports: clk, rst (async, active-high), flush; in_valid/in_ready/in_pc/in_inst
//        from fetch; out_valid/out_ready and decoded out_* fields to dispatch.
module inst_decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NAME_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [DATA_W-1:0]  in_inst,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [NAME_W-1:0]  out_rs1,
    output logic [NAME_W-1:0]  out_rs2,
    output logic [NAME_W-1:0]  out_rd,
    output op_t                out_op,
    output logic [CLASS_W-1:0] out_class,
    output logic [DATA_W-1:0]  out_imm,
    output logic               out_use_rs1,
    output logic               out_use_rs2,
    output logic               out_wr_rd,
    output logic               out_illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              push_c, load_c;

    op_t               dec_op_c;
    logic [CLASS_W-1:0] dec_cls_c;
    logic [DATA_W-1:0] dec_imm_c;
    logic [NAME_W-1:0] dec_rs1_c, dec_rs2_c, dec_rd_c;
    logic              dec_use_rs1_c, dec_use_rs2_c, dec_wr_rd_c, dec_illegal_c;

    assign push_c = in_valid && in_ready && !flush;
    assign load_c = (count != '0) && (!out_valid || out_ready) && !flush;

    // Occupancy update; push+pop together leaves count unchanged
    always_comb begin
        count_nxt = count;
        case ({push_c, load_c})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Pointers, count and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            in_ready <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    rv32i_decode_comb #(
        .DATA_W (DATA_W),
        .NAME_W (NAME_W)
    ) u_dec (
        .inst      (inst_mem[rd_ptr]),
        .op_c      (dec_op_c),
        .cls_c     (dec_cls_c),
        .imm_c     (dec_imm_c),
        .rs1_c     (dec_rs1_c),
        .rs2_c     (dec_rs2_c),
        .rd_c      (dec_rd_c),
        .use_rs1_c (dec_use_rs1_c),
        .use_rs2_c (dec_use_rs2_c),
        .wr_rd_c   (dec_wr_rd_c),
        .illegal_c (dec_illegal_c)
    );

    // Output micro-op register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_op      <= OP_NOP;
            out_class   <= CLASS_NOP;
            out_imm     <= '0;
            out_use_rs1 <= 1'b0;
            out_use_rs2 <= 1'b0;
            out_wr_rd   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_c) begin
            out_valid   <= 1'b1;
            out_pc      <= pc_mem[rd_ptr];
            out_rs1     <= dec_rs1_c;
            out_rs2     <= dec_rs2_c;
            out_rd      <= dec_rd_c;
            out_op      <= dec_op_c;
            out_class   <= dec_cls_c;
            out_imm     <= dec_imm_c;
            out_use_rs1 <= dec_use_rs1_c;
            out_use_rs2 <= dec_use_rs2_c;
            out_wr_rd   <= dec_wr_rd_c;
            out_illegal <= dec_illegal_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_decode_queue.sv
// Self-checking bench for inst_decode_queue: table of directed decode
// vectors plus hand-written backpressure, flush and async-reset sequences.
module tb_inst_decode_queue;
    import decode_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NAME_W = 5;
    localparam int unsigned NVEC   = 15;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [ADDR_W-1:0] in_pc, out_pc;
    logic [DATA_W-1:0] in_inst, out_imm;
    logic [NAME_W-1:0] out_rs1, out_rs2, out_rd;
    op_t               out_op;
    logic [6:0]        out_class;
    logic              out_use_rs1, out_use_rs2, out_wr_rd, out_illegal;

    int checks = 0;
    int fails  = 0;

    inst_decode_queue #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .NAME_W (NAME_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_op      (out_op),
        .out_class   (out_class),
        .out_imm     (out_imm),
        .out_use_rs1 (out_use_rs1),
        .out_use_rs2 (out_use_rs2),
        .out_wr_rd   (out_wr_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        op_t         op;
        logic [6:0]  cls;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        u1, u2, wr, ill;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [31:0] inst, input op_t op, input logic [6:0] cls,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic u1, input logic u2,
                                input logic wr, input logic ill);
        vec_t v;
        v.inst = inst; v.op = op; v.cls = cls; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.imm = imm; v.u1 = u1; v.u2 = u2; v.wr = wr; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".out_op"},    64'(out_op),    64'(OP_NOP));
        chk({tag, ".out_class"}, 64'(out_class), 64'(CLASS_NOP));
        chk({tag, ".out_pc"},    64'(out_pc),    64'd0);
        chk({tag, ".out_imm"},   64'(out_imm),   64'd0);
        chk({tag, ".flags"},     64'({out_use_rs1, out_use_rs2, out_wr_rd, out_illegal}), 64'd0);
    endtask

    // Push one pair on an empty pipe (out_ready=1) and check 2-edge latency
    task automatic push_and_check(input vec_t v, input logic [31:0] pc, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_pc = pc; in_inst = v.inst;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".pc"},    64'(out_pc),    64'(pc));
        chk({tag, ".op"},    64'(out_op),    64'(v.op));
        chk({tag, ".class"}, 64'(out_class), 64'(v.cls));
        chk({tag, ".names"}, 64'({out_rs1, out_rs2, out_rd}), 64'({v.rs1, v.rs2, v.rd}));
        chk({tag, ".imm"},   64'(out_imm),   64'(v.imm));
        chk({tag, ".flags"}, 64'({out_use_rs1, out_use_rs2, out_wr_rd, out_illegal}),
                             64'({v.u1, v.u2, v.wr, v.ill}));
    endtask

    // With out_ready=0, push addi x1,x0,k pairs until in_ready drops
    task automatic fill(input logic [31:0] base, output int acc);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!in_ready) break;
            in_valid = 1'b1;
            in_pc    = base + 32'(4 * k);
            in_inst  = {12'(k), 20'h00093};
            acc++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int seen;

        vecs[0]  = mk(32'h00500093, OP_ADD,   CLS_RI,    5'd0, 5'd0, 5'd1,  32'h00000005, 1, 0, 1, 0);
        vecs[1]  = mk(32'h402081B3, OP_SUB,   CLS_RR,    5'd1, 5'd2, 5'd3,  32'h00000000, 1, 1, 1, 0);
        vecs[2]  = mk(32'h123452B7, OP_LUI,   CLS_LUI,   5'd0, 5'd0, 5'd5,  32'h12345000, 0, 0, 1, 0);
        vecs[3]  = mk(32'hFE208EE3, OP_BEQ,   CLS_B,     5'd1, 5'd2, 5'd0,  32'hFFFFFFFC, 1, 1, 0, 0);
        vecs[4]  = mk(32'hFFFFFFFF, OP_NOP,   CLASS_NOP, 5'd0, 5'd0, 5'd0,  32'h00000000, 0, 0, 0, 1);
        vecs[5]  = mk(32'h00009067, OP_NOP,   CLASS_NOP, 5'd0, 5'd0, 5'd0,  32'h00000000, 0, 0, 0, 1);
        vecs[6]  = mk(32'h00512423, OP_SW,    CLS_ST,    5'd2, 5'd5, 5'd0,  32'h00000008, 1, 1, 0, 0);
        vecs[7]  = mk(32'h010000EF, OP_JAL,   CLS_JAL,   5'd0, 5'd0, 5'd1,  32'h00000010, 0, 0, 1, 0);
        vecs[8]  = mk(32'hFFC1A303, OP_LW,    CLS_LD,    5'd3, 5'd0, 5'd6,  32'hFFFFFFFC, 1, 0, 1, 0);
        vecs[9]  = mk(32'h4033D393, OP_SRA,   CLS_RI,    5'd7, 5'd0, 5'd7,  32'h00000403, 1, 0, 1, 0);
        vecs[10] = mk(32'h40339393, OP_NOP,   CLASS_NOP, 5'd0, 5'd0, 5'd0,  32'h00000000, 0, 0, 0, 1);
        vecs[11] = mk(32'h00000013, OP_ADD,   CLS_RI,    5'd0, 5'd0, 5'd0,  32'h00000000, 1, 0, 0, 0);
        vecs[12] = mk(32'hFFFFF517, OP_AUIPC, CLS_AUIPC, 5'd0, 5'd0, 5'd10, 32'hFFFFF000, 0, 0, 1, 0);
        vecs[13] = mk(32'h4020F1B3, OP_NOP,   CLASS_NOP, 5'd0, 5'd0, 5'd0,  32'h00000000, 0, 0, 0, 1);
        vecs[14] = mk(32'h0020A063, OP_NOP,   CLASS_NOP, 5'd0, 5'd0, 5'd0,  32'h00000000, 0, 0, 0, 1);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_inst = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Directed decode table
        for (int i = 0; i < int'(NVEC); i++)
            push_and_check(vecs[i], 32'h1000 + 32'(4 * i), $sformatf("vec%0d", i));

        // Backpressure: DEPTH in FIFO plus one in the output register
        @(negedge clk);
        out_ready = 1'b0;
        fill(32'h2000, acc);
        chk("bp.accepted", 64'(acc), 64'(DEPTH + 1));
        chk("bp.in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        chk("bp.hold_valid", 64'(out_valid), 64'd1);
        chk("bp.hold_pc",    64'(out_pc),    64'h2000);
        out_ready = 1'b1;
        for (int j = 0; j <= int'(DEPTH); j++) begin
            chk($sformatf("bp.valid%0d", j), 64'(out_valid), 64'd1);
            chk($sformatf("bp.pc%0d", j),    64'(out_pc),    64'(32'h2000 + 32'(4 * j)));
            chk($sformatf("bp.imm%0d", j),   64'(out_imm),   64'(j));
            @(negedge clk);
        end
        chk("bp.drained",  64'(out_valid), 64'd0);
        chk("bp.ready_up", 64'(in_ready),  64'd1);

        // Flush with full FIFO and a same-cycle offered pair
        out_ready = 1'b0;
        fill(32'h3000, acc);
        chk("fl.accepted", 64'(acc), 64'(DEPTH + 1));
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD0; in_inst = 32'h00700093;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.out_valid", 64'(out_valid), 64'd0);
        chk("fl.in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("fl.no_output", 64'(seen), 64'd0);
        push_and_check(vecs[0], 32'h4000, "fl.post");

        // Asynchronous reset between edges, mid-stream
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h5000; in_inst = vecs[1].inst;
        @(negedge clk);
        in_pc = 32'h5004; in_inst = vecs[2].inst;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar.pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("ar");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push_and_check(vecs[3], 32'h6000, "ar.post");
        @(negedge clk);
        chk("ar.empty", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
